// File: rtl/hilo_muldiv_if.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_if
//   Request/result bundle between the control unit and the HI/LO
//   multiply/divide sequencer.
//   master : control unit side  (drives start/op/a/b, observes results)
//   slave  : sequencer side     (observes request, drives results)
//   Signals:
//     start       request pulse, only honoured while the sequencer is idle
//     op          00 MUL, 01 MULU, 10 DIV, 11 DIVU
//     a, b        multiplicand/dividend, multiplier/divisor
//     busy        sequencer not idle
//     done        one-cycle completion pulse
//     hi_en/lo_en HI/LO load enables (equal to done)
//     hi_data     MUL high product word / DIV remainder
//     lo_data     MUL low product word  / DIV quotient
//     div_by_zero qualifies done for a divide with zero divisor
// ---------------------------------------------------------------------------
interface hilo_muldiv_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  busy;
    logic                  done;
    logic                  hi_en;
    logic                  lo_en;
    logic [DATA_WIDTH-1:0] hi_data;
    logic [DATA_WIDTH-1:0] lo_data;
    logic                  div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi_en, lo_en, hi_data, lo_data, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi_en, lo_en, hi_data, lo_data, div_by_zero
    );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_ctrl
//   Iterative multiply/divide sequencer producing the HI/LO result pair.
//   Shift-add multiply and restoring divide, one result bit per clock, on
//   operand magnitudes; a single FIX cycle restores signs for signed ops.
//   FSM: IDLE -> CALC (W cycles) -> FIX -> WRITE -> IDLE.
//   A divide by zero skips straight from IDLE to WRITE.
//   Ports:
//     clock  single clock, all state on posedge
//     clear  synchronous active-high reset, aborts any operation in flight
//     bus    hilo_muldiv_if.slave request/result bundle
// ---------------------------------------------------------------------------
module hilo_muldiv_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clock,
    input  logic          clear,
    hilo_muldiv_if.slave  bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIX   = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   count_reg;
    logic            is_div_reg;
    logic            sign_a_reg;
    logic            sign_b_reg;
    logic            dz_reg;
    // acc_reg: upper product word / partial remainder
    // low_reg: multiplier being consumed / dividend becoming quotient
    // opnd_reg: multiplicand / divisor magnitude
    logic [W-1:0]    acc_reg;
    logic [W-1:0]    low_reg;
    logic [W-1:0]    opnd_reg;
    logic [W-1:0]    hi_data_reg;
    logic [W-1:0]    lo_data_reg;

    // ---------------- request decode (IDLE) ----------------
    logic            req_div;
    logic            req_signed;
    logic            req_neg_a;
    logic            req_neg_b;
    logic            req_b_zero;
    logic [W-1:0]    req_mag_a;
    logic [W-1:0]    req_mag_b;

    always_comb begin
        req_div    = bus.op[1];
        req_signed = ~bus.op[0];
        req_neg_a  = req_signed & bus.a[W-1];
        req_neg_b  = req_signed & bus.b[W-1];
        req_b_zero = (bus.b == '0);
        // Magnitude taken as unsigned W bits: the most negative value maps to itself.
        req_mag_a  = req_neg_a ? (~bus.a + W'(1)) : bus.a;
        req_mag_b  = req_neg_b ? (~bus.b + W'(1)) : bus.b;
    end

    // ---------------- one iteration (CALC) ----------------
    logic [W:0]      mul_sum;
    logic [W:0]      div_shift;
    logic            div_ge;
    logic [W-1:0]    div_rem;

    always_comb begin
        mul_sum   = {1'b0, acc_reg} + (low_reg[0] ? {1'b0, opnd_reg} : {(W+1){1'b0}});
        // Partial remainder shifted left with the next dividend bit; W+1 bits
        // so the shifted-out MSB still takes part in the trial compare.
        div_shift = {acc_reg, low_reg[W-1]};
        div_ge    = (div_shift >= {1'b0, opnd_reg});
        // When the trial succeeds the difference is below the divisor, so W bits hold it.
        div_rem   = div_shift[W-1:0] - opnd_reg;
    end

    // ---------------- sign correction (FIX) ----------------
    logic [2*W-1:0]  product;
    logic [2*W-1:0]  product_fix;
    logic [W-1:0]    quo_fix;
    logic [W-1:0]    rem_fix;
    logic            neg_result;

    always_comb begin
        // Sign bits are zero for unsigned ops, so they pass through untouched.
        neg_result  = sign_a_reg ^ sign_b_reg;
        product     = {acc_reg, low_reg};
        product_fix = neg_result ? (~product + (2*W)'(1)) : product;
        quo_fix     = neg_result ? (~low_reg + W'(1)) : low_reg;
        rem_fix     = sign_a_reg ? (~acc_reg + W'(1)) : acc_reg;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = (req_div && req_b_zero) ? S_WRITE : S_CALC;
                end
            end
            S_CALC: begin
                if (count_reg == LAST_ITER) begin
                    state_next = S_FIX;
                end
            end
            S_FIX:   state_next = S_WRITE;
            S_WRITE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: Moore outputs ----------------
    logic busy_out;
    logic done_out;
    logic dz_out;

    always_comb begin
        busy_out = (state_reg != S_IDLE);
        done_out = (state_reg == S_WRITE);
        dz_out   = (state_reg == S_WRITE) & dz_reg;
    end

    assign bus.busy        = busy_out;
    assign bus.done        = done_out;
    assign bus.hi_en       = done_out;
    assign bus.lo_en       = done_out;
    assign bus.div_by_zero = dz_out;
    assign bus.hi_data     = hi_data_reg;
    assign bus.lo_data     = lo_data_reg;

    // ---------------- datapath ----------------
    always_ff @(posedge clock) begin
        if (clear) begin
            count_reg   <= '0;
            is_div_reg  <= 1'b0;
            sign_a_reg  <= 1'b0;
            sign_b_reg  <= 1'b0;
            dz_reg      <= 1'b0;
            acc_reg     <= '0;
            low_reg     <= '0;
            opnd_reg    <= '0;
            hi_data_reg <= '0;
            lo_data_reg <= '0;
        end else begin
            unique case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        count_reg  <= '0;
                        is_div_reg <= req_div;
                        sign_a_reg <= req_neg_a;
                        sign_b_reg <= req_neg_b;
                        acc_reg    <= '0;
                        if (req_div) begin
                            low_reg  <= req_mag_a;
                            opnd_reg <= req_mag_b;
                        end else begin
                            low_reg  <= req_mag_b;
                            opnd_reg <= req_mag_a;
                        end
                        // Zero divisor bypasses CALC/FIX, so the result is loaded now.
                        if (req_div && req_b_zero) begin
                            dz_reg      <= 1'b1;
                            hi_data_reg <= bus.a;
                            lo_data_reg <= '1;
                        end else begin
                            dz_reg <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    count_reg <= count_reg + CW'(1);
                    if (is_div_reg) begin
                        acc_reg <= div_ge ? div_rem : div_shift[W-1:0];
                        low_reg <= {low_reg[W-2:0], div_ge};
                    end else begin
                        acc_reg <= mul_sum[W:1];
                        low_reg <= {mul_sum[0], low_reg[W-1:1]};
                    end
                end
                S_FIX: begin
                    if (is_div_reg) begin
                        hi_data_reg <= rem_fix;
                        lo_data_reg <= quo_fix;
                    end else begin
                        hi_data_reg <= product_fix[2*W-1:W];
                        lo_data_reg <= product_fix[W-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hilo_muldiv_ctrl
//   Scoreboard bench for hilo_muldiv_ctrl: each request pushes its expected
//   HI/LO/div_by_zero triple; a monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_hilo_muldiv_ctrl;
    localparam int W = 32;

    logic clock;
    logic clear;

    hilo_muldiv_if #(.DATA_WIDTH(W)) bus ();

    hilo_muldiv_ctrl #(.DATA_WIDTH(W)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model built on 64-bit language arithmetic.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        longint      sa, sb, sp, sq, sr;
        logic [63:0] ua, ub, up, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        e.dz = 1'b0;
        if (op[1] && b == '0) begin
            e.hi = a;
            e.lo = '1;
            e.dz = 1'b1;
        end else begin
            case (op)
                2'b00: begin sp = sa * sb; up = 64'(sp); e.hi = up[63:32]; e.lo = up[31:0]; end
                2'b01: begin up = ua * ub; e.hi = up[63:32]; e.lo = up[31:0]; end
                2'b10: begin
                    sq = sa / sb; sr = sa % sb;
                    uq = 64'(sq); ur = 64'(sr);
                    e.hi = ur[31:0]; e.lo = uq[31:0];
                end
                default: begin uq = ua / ub; ur = ua % ub; e.hi = ur[31:0]; e.lo = uq[31:0]; end
            endcase
        end
        return e;
    endfunction

    // Monitor: compare on each done pulse, sampled on the falling edge.
    always @(negedge clock) begin
        exp_t e;
        if (bus.done === 1'b1) begin
            check_value("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_value("hi_data", 64'(bus.hi_data), 64'(e.hi));
                check_value("lo_data", 64'(bus.lo_data), 64'(e.lo));
                check_value("div_by_zero", 64'(bus.div_by_zero), 64'(e.dz));
                check_value("hi_en", 64'(bus.hi_en), 64'd1);
                check_value("lo_en", 64'(bus.lo_en), 64'd1);
                $display("op done: hi=0x%08h lo=0x%08h dz=%0b", bus.hi_data, bus.lo_data, bus.div_by_zero);
            end
        end
    end

    // Issue one request from a falling edge and follow it to completion.
    //   inject_at : sample index at which a conflicting start is pulsed (0 = none)
    //   clear_at  : sample index at which clear aborts the operation (0 = none)
    //   poke_write: drive a div-by-zero start during the WRITE cycle
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inject_at, input int clear_at, input bit poke_write);
        exp_t e;
        int   cycles;
        int   busy_cnt;
        int   exp_lat;
        bit   seen_done;
        e = model(op, a, b);
        exp_lat = e.dz ? 1 : W + 2;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        sb_q.push_back(e);
        @(posedge clock); @(negedge clock);
        bus.start = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom);
        cycles = 1; busy_cnt = 0; seen_done = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin seen_done = 1; break; end
            if (cycles == clear_at) begin
                clear = 1'b1;
                @(posedge clock); @(negedge clock);
                clear = 1'b0;
                void'(sb_q.pop_back());
                check_value("abort_busy", 64'(bus.busy), 64'd0);
                check_value("abort_hi_en", 64'(bus.hi_en), 64'd0);
                check_value("abort_hi_data", 64'(bus.hi_data), 64'd0);
                check_value("abort_lo_data", 64'(bus.lo_data), 64'd0);
                $display("op aborted by clear at cycle %0d", cycles);
                return;
            end
            if (cycles == inject_at) begin
                bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd123; bus.b = 32'd0;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clock); @(negedge clock);
            cycles++;
        end
        bus.start = 1'b0;
        if (!seen_done) begin
            check_value("timeout_done", 64'd0, 64'd1);
            void'(sb_q.pop_back());
            return;
        end
        check_value("latency", 64'(cycles), 64'(exp_lat));
        check_value("busy_cycles", 64'(busy_cnt), 64'(exp_lat));
        if (poke_write) begin
            bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd1; bus.b = 32'd0;
        end
        @(posedge clock); @(negedge clock);
        bus.start = 1'b0;
        check_value("done_one_cycle", 64'(bus.done), 64'd0);
        check_value("busy_after", 64'(bus.busy), 64'd0);
        check_value("lo_hold", 64'(bus.lo_data), 64'(e.lo));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;
        clear = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_value("reset_busy", 64'(bus.busy), 64'd0);
        check_value("reset_done", 64'(bus.done), 64'd0);
        check_value("reset_hi_en", 64'(bus.hi_en), 64'd0);
        check_value("reset_hi_data", 64'(bus.hi_data), 64'd0);
        check_value("reset_lo_data", 64'(bus.lo_data), 64'd0);
        check_value("reset_dz", 64'(bus.div_by_zero), 64'd0);
        clear = 1'b0;
        @(negedge clock);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 5, 0, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
        run_op(2'b11, 32'd100, 32'd7, 0, 0, 0);
        run_op(2'b11, 32'h0000_1234, 32'd0, 0, 0, 1);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0, 1);
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 0, 0, 0);
        run_op(2'b00, 32'd1234, 32'd5678, 0, 10, 0);
        // No late done may appear from the aborted operation.
        repeat (40) @(negedge clock);
        check_value("idle_after_abort", 64'(bus.busy), 64'd0);
        run_op(2'b10, 32'd1000, 32'hFFFF_FFF7, 0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            run_op(rop, ra, rb, 0, 0, 0);
        end

        check_value("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
